// File: rtl/mealy_pkg.sv
// mealy_pkg: shared FSM state type and default sizing for the sequence detector
package mealy_pkg;
  typedef enum logic {FILL, ARMED} state_t;
  localparam int DEF_PAT_LEN = 4;
  localparam int DEF_CNT_W = 4;
endpackage

// File: rtl/mealy_seq_det_sat_counter.sv
// sat_counter: saturating match counter with sticky overflow flag
// Ports: clk, reset (sync, active-low), clr (sync clear), inc (count request),
//        cnt (current count), sat (set when inc arrives while cnt is at max; cleared by reset/clr)
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc) begin
      if (&cnt) sat <= 1'b1;
      else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mealy_seq_det.sv
// mealy_seq_det: programmable serial pattern detector with Mealy match flag and saturating match count
// Ports: clk, reset (sync, active-low), en (bit valid), in (serial bit), load (take pattern_in),
//        pattern_in (new pattern, MSB = oldest bit), overlap (1 = matches may share bits),
//        z (combinational match flag), out (saturating match count), sat (sticky overflow)
module mealy_seq_det
  import mealy_pkg::*;
#(
  parameter int                  PAT_LEN = DEF_PAT_LEN,
  parameter int                  CNT_W   = DEF_CNT_W,
  parameter logic [PAT_LEN-1:0]  DEF_PAT = 4'b1011
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               in,
  input  logic               load,
  input  logic [PAT_LEN-1:0] pattern_in,
  input  logic               overlap,
  output logic               z,
  output logic [CNT_W-1:0]   out,
  output logic               sat
);
  localparam int HW = PAT_LEN - 1;
  localparam int FW = $clog2(PAT_LEN);
  localparam logic [FW-1:0] LAST = FW'(PAT_LEN - 1);
  state_t state, state_nxt;
  logic [PAT_LEN-1:0] pat_reg, pat_nxt;
  logic [HW-1:0] hist, hist_nxt;
  logic [FW-1:0] fill, fill_nxt;
  logic [PAT_LEN-1:0] win;
  logic match;
  // Window of the newest PAT_LEN bits, with the incoming bit in the LSB.
  assign win = {hist, in};
  assign match = reset & en & ~load & (state == ARMED) & (win == pat_reg);
  assign z = match;
  always_ff @(posedge clk) begin
    if (!reset) begin
      pat_reg <= DEF_PAT;
      hist    <= '0;
      fill    <= '0;
      state   <= FILL;
    end else begin
      pat_reg <= pat_nxt;
      hist    <= hist_nxt;
      fill    <= fill_nxt;
      state   <= state_nxt;
    end
  end
  // A non-overlapping match restarts filling so no matched bit is reused.
  always_comb begin
    pat_nxt   = load ? pattern_in : pat_reg;
    hist_nxt  = load ? '0 : en ? win[HW-1:0] : hist;
    fill_nxt  = load ? '0 : !en ? fill : match ? (overlap ? LAST : '0) :
                (state == FILL) ? fill + 1'b1 : fill;
    state_nxt = (fill_nxt == LAST) ? ARMED : FILL;
  end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (load),
    .inc   (match),
    .cnt   (out),
    .sat   (sat)
  );
endmodule
